acc_bank: RTL and testbench
===========================

Name: acc_bank

Overview:
- Parametrised successor to the single SAP accumulator: a bank of N accumulators, each W bits wide, on the shared tri-state system bus.
- Adds per-register ALU-side operations (clear, increment/decrement, shift, rotate) and a registered bus driver.
- A continuous output of the selected register feeds the ULA.
- Sits between the control unit (which supplies acc_in, acc_out, sel, op, op_en) and the bus/ULA.

Parameters:
- W, 8, data width of each accumulator and of the bus.
- N, 4, number of accumulators (N >= 1).
- SW, $clog2(N) (minimum 1), select width, derived.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- acc_in  in  1  load selected register from bus.
- acc_out  in  1  drive selected register onto bus (registered).
- sel  in  SW  register select for load, op and drive; values >= N are ignored (no load/op, bus released).
- op_en  in  1  apply op to selected register.
- op  in  3  operation code.
- bus  inout  W  shared system bus.
- acc_ula  out  W  combinational view of register[sel]; 0 if sel >= N.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow/shifted-out bit.
- flag_n  out  1  MSB of last result.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - all registers = 0; bus driver register = 0; drive enable = 0 (bus = Z).
  - flags = 0. Reset overrides every other input, including mid-operation.
- Load: acc_in=1 at an edge -> register[sel] <= bus; visible on acc_ula the same cycle after the edge.
- Op codes (applied at an edge when op_en=1 and acc_in=0):
  - 000 NOP
  - 001 CLR -> 0
  - 010 INC -> +1 mod 2^W
  - 011 DEC -> -1 mod 2^W
  - 100 SHL, LSB <= 0
  - 101 SHR, MSB <= 0
  - 110 ROL
  - 111 ROR
- Priority: acc_in over op_en; with both asserted, the load wins and the op is dropped.
- Carry out:
  - INC: 1 when wrapping all-ones -> 0.
  - DEC: 1 when wrapping 0 -> all-ones (borrow).
  - SHL/ROL: old MSB. SHR/ROR: old LSB.
  - CLR: 0.
- Flag updates (at the same edge as the register write):
  - Flags update only on a load or a non-NOP op.
  - flag_z = (result == 0); flag_n = result[W-1]; flag_c per the carry rules above, cleared by a load.
  - NOP or idle cycles hold the flags.
- Bus drive:
  - At each edge (no reset), drive enable <= acc_out & (sel < N), and the drive register <= register[sel] pre-update (old value if loaded/modified at the same edge).
  - bus = drive register when drive enable = 1, else Z.
  - One-cycle latency from acc_out to valid bus data; one-cycle latency to release.
- Simultaneous acc_in and acc_out on the same register: load takes the current bus value; the driver captures the old value. Bus contention from that case is the control unit's responsibility.
- Only the selected register changes; all others hold.

Optional Feature:
- Macro ACC_BANK_XFER_EN.
- When defined: op 000 with op_en=1 becomes XFER (register-to-register copy) instead of NOP.
  - Adds input port src (SW bits).
  - XFER: register[sel] <= register[src]; flags updated as for a load (z, n from value, c=0).
  - src >= N -> treated as NOP.
- When undefined: no src port; op 000 is NOP.

Decomposition:
- Package acc_pkg:
  - op code localparams (OP_NOP, OP_CLR, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_ROL, OP_ROR).
  - a 3-bit op typedef.
- Sub-module acc_bus_drv (parameter W):
  - inputs: clock, reset, en, d.
  - inout: bus.
  - function: registered tri-state driver, reused by other bus-attached registers.
- The register array, op unit and flag logic stay in acc_bank.

Test Plan (W=8, N=4):
- Reset: set regs, assert reset one edge -> all acc_ula reads 0, flags 0, bus Z at next cycle.
- Load/drive:
  - bus=0xA5, acc_in=1, sel=2 -> acc_ula=0xA5.
  - Next: acc_out=1 -> bus=0xA5 one cycle later.
  - acc_out=0 -> bus Z one cycle later.
- Wrap and flags:
  - reg1=0xFF, INC -> 0x00, z=1, c=1, n=0.
  - Then DEC -> 0xFF, z=0, c=1, n=1.
- Shift/rotate:
  - reg0=0x81: ROL -> 0x03, c=1.
  - Then SHR -> 0x01, c=1.
  - Then SHL -> 0x02, c=0.
- Priority and isolation:
  - acc_in=1, op_en=1 INC, bus=0x10, sel=3 -> reg3=0x10 (no INC), c=0.
  - Regs 0–2 unchanged. sel=3 with acc_out=1 that edge -> bus shows old reg3.
- Reset mid-drive and out-of-range select:
  - While driving 0x5A, assert reset -> bus Z at next cycle, regs 0.
  - sel of an unused code with N=3 build -> acc_in ignored, acc_ula=0, bus Z.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared op codes and types for the accumulator bank.
package acc_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] acc_op_t;

  localparam acc_op_t OP_NOP = 3'b000;
  localparam acc_op_t OP_CLR = 3'b001;
  localparam acc_op_t OP_INC = 3'b010;
  localparam acc_op_t OP_DEC = 3'b011;
  localparam acc_op_t OP_SHL = 3'b100;
  localparam acc_op_t OP_SHR = 3'b101;
  localparam acc_op_t OP_ROL = 3'b110;
  localparam acc_op_t OP_ROR = 3'b111;

endpackage

// File: rtl/acc_bus_drv.sv
// Registered tri-state bus driver: enable and data are captured on the clock edge,
// so both driving and releasing the bus take effect one cycle after the request.
module acc_bus_drv
  import acc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  inout  wire  [W-1:0] bus
);

  logic         en_q, en_d;
  logic [W-1:0] d_q, d_d;

  always_comb begin
    en_d = en;
    d_d  = d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q <= 1'b0;
      d_q  <= '0;
    end else begin
      en_q <= en_d;
      d_q  <= d_d;
    end
  end

  assign bus = en_q ? d_q : 'z;

endmodule

// File: rtl/acc_bank.sv
// Bank of N W-bit accumulators on the shared bus, with per-register ALU ops and flags.
// Optional ACC_BANK_XFER_EN turns op 000 into a register-to-register copy from src.
module acc_bank
  import acc_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          acc_in,
  input  logic          acc_out,
  input  logic [SW-1:0] sel,
  input  logic          op_en,
  input  acc_op_t       op,
`ifdef ACC_BANK_XFER_EN
  input  logic [SW-1:0] src,
`endif
  inout  wire  [W-1:0]  bus,
  output logic [W-1:0]  acc_ula,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_n
);

  logic [W-1:0] regs_q [N];
  logic [W-1:0] regs_d [N];
  logic         flag_z_q, flag_z_d;
  logic         flag_c_q, flag_c_d;
  logic         flag_n_q, flag_n_d;

  logic         sel_ok;
  logic [W-1:0] cur;
  logic [W-1:0] res;
  logic         res_c;
  logic         res_upd;
  logic         drv_en;

  always_comb begin
    sel_ok = (32'(sel) < N);
    cur    = sel_ok ? regs_q[sel] : '0;
  end

  // Op unit: result and carry for the selected register; res_upd marks ops that write.
  always_comb begin
    res     = cur;
    res_c   = 1'b0;
    res_upd = 1'b0;
    case (op)
      OP_CLR: begin
        res     = '0;
        res_upd = 1'b1;
      end
      OP_INC: begin
        {res_c, res} = (W+1)'(cur) + (W+1)'(1);
        res_upd      = 1'b1;
      end
      OP_DEC: begin
        {res_c, res} = (W+1)'(cur) - (W+1)'(1);
        res_upd      = 1'b1;
      end
      OP_SHL: begin
        res     = {cur[W-2:0], 1'b0};
        res_c   = cur[W-1];
        res_upd = 1'b1;
      end
      OP_SHR: begin
        res     = {1'b0, cur[W-1:1]};
        res_c   = cur[0];
        res_upd = 1'b1;
      end
      OP_ROL: begin
        res     = {cur[W-2:0], cur[W-1]};
        res_c   = cur[W-1];
        res_upd = 1'b1;
      end
      OP_ROR: begin
        res     = {cur[0], cur[W-1:1]};
        res_c   = cur[0];
        res_upd = 1'b1;
      end
      default: begin
`ifdef ACC_BANK_XFER_EN
        if (32'(src) < N) begin
          res     = regs_q[src];
          res_upd = 1'b1;
        end
`endif
      end
    endcase
  end

  // Register and flag next-state; a load beats a simultaneous op.
  always_comb begin
    regs_d   = regs_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_n_d = flag_n_q;
    if (sel_ok && acc_in) begin
      regs_d[sel] = bus;
      flag_z_d    = (bus == '0);
      flag_n_d    = bus[W-1];
      flag_c_d    = 1'b0;
    end else if (sel_ok && op_en && res_upd) begin
      regs_d[sel] = res;
      flag_z_d    = (res == '0);
      flag_n_d    = res[W-1];
      flag_c_d    = res_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_n_q <= flag_n_d;
    end
  end

  // Driver samples the pre-update value of the selected register.
  always_comb begin
    drv_en = acc_out & sel_ok;
  end

  acc_bus_drv #(
    .W (W)
  ) u_bus_drv (
    .clock (clock),
    .reset (reset),
    .en    (drv_en),
    .d     (cur),
    .bus   (bus)
  );

  assign acc_ula = cur;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign flag_n  = flag_n_q;

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank: an N=4 instance for the main function and an N=3
// instance for out-of-range selects. Bus release is probed by driving 0x00 from the bench.
module tb_acc_bank;
  import acc_pkg::*;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       acc_in  = 1'b0;
  logic       acc_out = 1'b0;
  logic       op_en   = 1'b0;
  logic [1:0] sel     = 2'd0;
  acc_op_t    op      = OP_NOP;
  logic       tb_en   = 1'b0;
  logic [7:0] tb_val  = 8'h00;
  wire  [7:0] bus;
  logic [7:0] acc_ula;
  logic       flag_z, flag_c, flag_n;

  logic       acc_in3  = 1'b0;
  logic       acc_out3 = 1'b0;
  logic [1:0] sel3     = 2'd0;
  logic       tb_en3   = 1'b0;
  logic [7:0] tb_val3  = 8'h00;
  wire  [7:0] bus3;
  logic [7:0] acc_ula3;
  logic       flag_z3, flag_c3, flag_n3;

`ifdef ACC_BANK_XFER_EN
  logic [1:0] src  = 2'd0;
  logic [1:0] src3 = 2'd0;
`endif

  int n_vec = 0;
  int n_err = 0;

  assign bus  = tb_en  ? tb_val  : 'z;
  assign bus3 = tb_en3 ? tb_val3 : 'z;

  always #5 clock = ~clock;

  acc_bank #(.W(8), .N(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .acc_in  (acc_in),
    .acc_out (acc_out),
    .sel     (sel),
    .op_en   (op_en),
    .op      (op),
`ifdef ACC_BANK_XFER_EN
    .src     (src),
`endif
    .bus     (bus),
    .acc_ula (acc_ula),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .flag_n  (flag_n)
  );

  acc_bank #(.W(8), .N(3)) dut3 (
    .clock   (clock),
    .reset   (reset),
    .acc_in  (acc_in3),
    .acc_out (acc_out3),
    .sel     (sel3),
    .op_en   (1'b0),
    .op      (OP_NOP),
`ifdef ACC_BANK_XFER_EN
    .src     (src3),
`endif
    .bus     (bus3),
    .acc_ula (acc_ula3),
    .flag_z  (flag_z3),
    .flag_c  (flag_c3),
    .flag_n  (flag_n3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic c, input logic n);
    chk({tag, "_z"}, 32'(flag_z), 32'(z));
    chk({tag, "_c"}, 32'(flag_c), 32'(c));
    chk({tag, "_n"}, 32'(flag_n), 32'(n));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] s, input logic [7:0] v);
    sel    = s;
    acc_in = 1'b1;
    tb_en  = 1'b1;
    tb_val = v;
    tick();
    acc_in = 1'b0;
    tb_en  = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] s, input acc_op_t o);
    sel   = s;
    op    = o;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    op    = OP_NOP;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ula", 32'(acc_ula), 32'h00);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);

    // Reset overrides loaded registers and a pending drive request
    load(2'd0, 8'h11);
    load(2'd1, 8'h22);
    load(2'd2, 8'h33);
    load(2'd3, 8'h44);
    sel     = 2'd1;
    acc_out = 1'b1;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    acc_out = 1'b0;
    tb_en   = 1'b1;
    tb_val  = 8'h00;
    #1;
    chk("rst2_bus", 32'(bus), 32'h00);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("rst2_reg", 32'(acc_ula), 32'h00);
    end
    chk_flags("rst2", 1'b0, 1'b0, 1'b0);
    tb_en = 1'b0;

    // Load and registered drive / release
    load(2'd2, 8'hA5);
    chk("ld_a5", 32'(acc_ula), 32'hA5);
    chk_flags("ld_a5", 1'b0, 1'b0, 1'b1);
    load(2'd3, 8'h44);
    sel     = 2'd2;
    acc_out = 1'b1;
    tick();
    acc_out = 1'b0;
    chk("drv_a5", 32'(bus), 32'hA5);
    tick();
    tb_en  = 1'b1;
    tb_val = 8'h00;
    #1;
    chk("release", 32'(bus), 32'h00);
    tb_en = 1'b0;

    // Wrap and flags
    load(2'd1, 8'hFF);
    do_op(2'd1, OP_INC);
    chk("inc_wrap", 32'(acc_ula), 32'h00);
    chk_flags("inc_wrap", 1'b1, 1'b1, 1'b0);
    do_op(2'd1, OP_DEC);
    chk("dec_wrap", 32'(acc_ula), 32'hFF);
    chk_flags("dec_wrap", 1'b0, 1'b1, 1'b1);

    // Shift / rotate chain
    load(2'd0, 8'h81);
    do_op(2'd0, OP_ROL);
    chk("rol", 32'(acc_ula), 32'h03);
    chk_flags("rol", 1'b0, 1'b1, 1'b0);
    do_op(2'd0, OP_SHR);
    chk("shr", 32'(acc_ula), 32'h01);
    chk_flags("shr", 1'b0, 1'b1, 1'b0);
    do_op(2'd0, OP_SHL);
    chk("shl", 32'(acc_ula), 32'h02);
    chk_flags("shl", 1'b0, 1'b0, 1'b0);
    do_op(2'd0, OP_ROR);
    chk("ror1", 32'(acc_ula), 32'h01);
    chk_flags("ror1", 1'b0, 1'b0, 1'b0);
    do_op(2'd0, OP_ROR);
    chk("ror2", 32'(acc_ula), 32'h80);
    chk_flags("ror2", 1'b0, 1'b1, 1'b1);
`ifndef ACC_BANK_XFER_EN
    do_op(2'd0, OP_NOP);
    chk("nop", 32'(acc_ula), 32'h80);
    chk_flags("nop", 1'b0, 1'b1, 1'b1);
`endif

    // Load beats op; driver captures the old value; other registers untouched
    sel     = 2'd3;
    acc_in  = 1'b1;
    op_en   = 1'b1;
    op      = OP_INC;
    acc_out = 1'b1;
    tb_en   = 1'b1;
    tb_val  = 8'h10;
    tick();
    acc_in  = 1'b0;
    op_en   = 1'b0;
    op      = OP_NOP;
    acc_out = 1'b0;
    tb_en   = 1'b0;
    #1;
    chk("prio_val", 32'(acc_ula), 32'h10);
    chk_flags("prio", 1'b0, 1'b0, 1'b0);
    chk("prio_bus_old", 32'(bus), 32'h44);
    sel = 2'd0;
    #1;
    chk("iso_r0", 32'(acc_ula), 32'h80);
    sel = 2'd1;
    #1;
    chk("iso_r1", 32'(acc_ula), 32'hFF);
    sel = 2'd2;
    #1;
    chk("iso_r2", 32'(acc_ula), 32'hA5);
    tick();

    do_op(2'd0, OP_CLR);
    chk("clr", 32'(acc_ula), 32'h00);
    chk_flags("clr", 1'b1, 1'b0, 1'b0);
    load(2'd0, 8'h7F);
    do_op(2'd0, OP_INC);
    chk("inc_nowrap", 32'(acc_ula), 32'h80);
    chk_flags("inc_nowrap", 1'b0, 1'b0, 1'b1);

    // Reset while driving
    load(2'd2, 8'h5A);
    sel     = 2'd2;
    acc_out = 1'b1;
    tick();
    chk("drv_5a", 32'(bus), 32'h5A);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    acc_out = 1'b0;
    tb_en   = 1'b1;
    tb_val  = 8'h00;
    #1;
    chk("rst_drv_bus", 32'(bus), 32'h00);
    chk("rst_drv_reg", 32'(acc_ula), 32'h00);
    tb_en = 1'b0;

    // N=3 instance: select code 3 is unused
    sel3    = 2'd2;
    acc_in3 = 1'b1;
    tb_en3  = 1'b1;
    tb_val3 = 8'h77;
    tick();
    acc_in3 = 1'b0;
    tb_en3  = 1'b0;
    chk("n3_ld2", 32'(acc_ula3), 32'h77);
    sel3     = 2'd3;
    acc_in3  = 1'b1;
    acc_out3 = 1'b1;
    tb_en3   = 1'b1;
    tb_val3  = 8'h99;
    tick();
    acc_in3  = 1'b0;
    acc_out3 = 1'b0;
    tb_val3  = 8'h00;
    #1;
    chk("n3_oor_bus", 32'(bus3), 32'h00);
    chk("n3_oor_ula", 32'(acc_ula3), 32'h00);
    chk("n3_oor_fn", 32'(flag_n3), 32'h0);
    chk("n3_oor_fz", 32'(flag_z3), 32'h0);
    tb_en3 = 1'b0;
    sel3   = 2'd2;
    #1;
    chk("n3_r2_keep", 32'(acc_ula3), 32'h77);
    sel3 = 2'd0;
    #1;
    chk("n3_r0_keep", 32'(acc_ula3), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
